// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch/exec memory port arbiter.
package riscv_pkg;

   localparam int unsigned DEFAULT_MAX_WAIT = 4;
   localparam int unsigned DEFAULT_AW       = 32;
   // Widest address the latched command can carry; AW must not exceed it.
   localparam int unsigned CMD_AW           = 32;
   localparam int unsigned DATA_W           = 32;
   localparam int unsigned STRB_W           = 4;
   // Wide enough for a MAX_WAIT of up to 15.
   localparam int unsigned STARVE_W         = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RESP = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2
   } arb_owner_t;

   typedef struct packed {
      logic              we;
      logic [CMD_AW-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } mem_cmd_t;

   // Saturating increment used by the fetch starvation counter.
   function automatic logic [STARVE_W-1:0] starve_inc(
      input logic [STARVE_W-1:0] cnt,
      input logic [STARVE_W-1:0] limit
   );
      return (cnt >= limit) ? limit : cnt + STARVE_W'(1);
   endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// grant is one-hot: bit 0 = fetch, bit 1 = data, 2'b00 = nobody requesting.
module arb_pick
   import riscv_pkg::*;
#(
   parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
   input  logic                if_req,
   input  logic                d_req,
   input  logic [STARVE_W-1:0] starve_cnt,
   output logic [1:0]          grant
);

   localparam logic [STARVE_W-1:0] MAX_CNT = STARVE_W'(MAX_WAIT);

   // Data wins contention unless fetch has already lost MAX_WAIT times in a row.
   always_comb begin
      grant = 2'b00;
      if (d_req && if_req) begin
         grant = (starve_cnt == MAX_CNT) ? 2'b01 : 2'b10;
      end else if (d_req) begin
         grant = 2'b10;
      end else if (if_req) begin
         grant = 2'b01;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and exec stages.
// One transaction in flight: IDLE picks and latches a command, ISSUE holds
// mem_req until mem_gnt, WAIT_RESP routes the single response to the owner.
//
// Handshake: a requester holds req and its command until it sees gnt, which is
// only ever asserted in IDLE and combinationally in the same cycle; the memory
// accepts in the cycle mem_req && mem_gnt and answers later with a one-cycle
// mem_rvalid, which is forwarded as a one-cycle rvalid to the owner only.
module mem_port_arbiter
   import riscv_pkg::*;
#(
   parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT,
   parameter int unsigned AW       = DEFAULT_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   // fetch port
   input  logic              if_req,
   input  logic [AW-1:0]     if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   // data port
   input  logic              d_req,
   input  logic              d_we,
   input  logic [AW-1:0]     d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [STRB_W-1:0] d_wstrb,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   // memory port
   output logic              mem_req,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [STRB_W-1:0] mem_wstrb,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t          state_q, state_d;
   arb_owner_t          owner_q, owner_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   mem_cmd_t            cmd_q, cmd_d;
   logic [1:0]          pick;

   arb_pick #(
      .MAX_WAIT (MAX_WAIT)
   ) u_pick (
      .if_req     (if_req),
      .d_req      (d_req),
      .starve_cnt (starve_q),
      .grant      (pick)
   );

   // Next-state, grant and response routing; every output defaults to 0.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      starve_d  = starve_q;
      cmd_d     = cmd_q;
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      if_rvalid = 1'b0;
      if_rdata  = '0;
      d_rvalid  = 1'b0;
      d_rdata   = '0;
      mem_req   = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Grants are combinational, so they are suppressed while reset is held.
            // Any mem_rvalid here is stale and deliberately dropped.
            if (rst_n) begin
               if (pick[1]) begin
                  d_gnt       = 1'b1;
                  owner_d     = DATA;
                  state_d     = ISSUE;
                  cmd_d.we    = d_we;
                  cmd_d.addr  = CMD_AW'(d_addr);
                  cmd_d.wdata = d_we ? d_wdata : '0;
                  cmd_d.wstrb = d_we ? d_wstrb : '0;
                  if (if_req) begin
                     starve_d = starve_inc(starve_q, STARVE_W'(MAX_WAIT));
                  end
               end else if (pick[0]) begin
                  if_gnt      = 1'b1;
                  owner_d     = FETCH;
                  state_d     = ISSUE;
                  cmd_d.we    = 1'b0;
                  cmd_d.addr  = CMD_AW'(if_addr);
                  cmd_d.wdata = '0;
                  cmd_d.wstrb = '0;
                  starve_d    = '0;
               end
            end
         end

         ISSUE: begin
            // Responses cannot precede acceptance, so mem_rvalid is ignored here.
            mem_req = 1'b1;
            if (mem_gnt) begin
               state_d = WAIT_RESP;
            end
         end

         WAIT_RESP: begin
            if (mem_rvalid) begin
               if (owner_q == FETCH) begin
                  if_rvalid = 1'b1;
                  if_rdata  = mem_rdata;
               end else if (owner_q == DATA) begin
                  d_rvalid = 1'b1;
                  d_rdata  = cmd_q.we ? '0 : mem_rdata;
               end
               state_d = IDLE;
               owner_d = NONE;
            end
         end

         default: begin
            state_d = IDLE;
            owner_d = NONE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Owner, starvation counter and latched memory command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q  <= NONE;
         starve_q <= '0;
         cmd_q    <= '0;
      end else begin
         owner_q  <= owner_d;
         starve_q <= starve_d;
         cmd_q    <= cmd_d;
      end
   end

   assign mem_we    = cmd_q.we;
   assign mem_addr  = cmd_q.addr[AW-1:0];
   assign mem_wdata = cmd_q.wdata;
   assign mem_wstrb = cmd_q.wstrb;

endmodule
